// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver: divider-paced digit scan, per-frame snapshot
// of value/dp/enable, optional leading-zero blanking, registered active-low outputs.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [15:0]      snap_val;
  logic [3:0]       snap_dp;
  logic [3:0]       snap_en;
  logic             load_pend;

  logic             tick;
  logic             load;
  logic [3:0]       nib;
  logic [3:0]       zero_hi;
  logic             blank;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick = (div_cnt == DIV_LAST);
  // Frame boundary: leaving digit 3, so the new frame starts on a fresh snapshot.
  assign load = load_pend | (tick & (idx == 2'd3));

  always_comb begin
    nib        = snap_val[{idx, 2'b00} +: 4];
    zero_hi[3] = (snap_val[15:12] == 4'h0);
    zero_hi[2] = zero_hi[3] & (snap_val[11:8] == 4'h0);
    zero_hi[1] = zero_hi[2] & (snap_val[7:4] == 4'h0);
    zero_hi[0] = zero_hi[1] & (snap_val[3:0] == 4'h0);
    blank      = ~snap_en[idx] | (LZ_BLANK && (idx != 2'd0) && zero_hi[idx]);
    an_nxt     = 4'b1111;
    seg_nxt    = 7'h7F;
    dp_nxt     = 1'b1;
    if (!blank) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = hex7(nib);
      dp_nxt  = ~snap_dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      idx       <= 2'd0;
      snap_val  <= 16'h0000;
      snap_dp   <= 4'h0;
      snap_en   <= 4'h0;
      load_pend <= 1'b1;
      an        <= 4'b1111;
      seg       <= 7'h7F;
      dp        <= 1'b1;
    end else begin
      div_cnt   <= tick ? '0 : div_cnt + CNT_W'(1);
      if (tick) idx <= idx + 2'd1;
      if (load) begin
        snap_val <= value;
        snap_dp  <= dp_in;
        snap_en  <= digit_en;
      end
      load_pend <= 1'b0;
      an        <= an_nxt;
      seg       <= seg_nxt;
      dp        <= dp_nxt;
    end
  end

endmodule
